prism_shift_fifo: RTL and testbench

//  Parametrised serial shift engine plus DEPTH-entry word FIFO, slaved to PRISM SHIFT strobes.

---
 rtl/prism_pkg.sv | 17 +
 rtl/prism_sync_fifo.sv | 52 +++++
 rtl/prism_shift_fifo.sv | 153 +++++++++++++++
 tb/tb_prism_shift_fifo.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prism_pkg.sv
// Shared constants and helpers for the PRISM shift/FIFO block.
package prism_pkg;

  localparam logic PRISM_MODE_RX = 1'b0;
  localparam logic PRISM_MODE_TX = 1'b1;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_e;

  // Width needed to hold an occupancy value 0..depth inclusive.
  function automatic int prism_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/prism_sync_fifo.sv
// Registered-array word FIFO with any integer depth; head reads 0 when empty.
module prism_sync_fifo
  import prism_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int CW    = prism_cnt_w(DEPTH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/prism_shift_fifo.sv
// Serial shift engine plus word FIFO driven by PRISM shift strobes (RX or TX).
// Optional threshold interrupt: define PRISM_FIFO_THRESH_EN to add the thresh port.
module prism_shift_fifo
  import prism_pkg::*;
#(
  parameter int   DATA_W = 8,
  parameter int   DEPTH  = 4,
  parameter logic IDLE   = 1'b1,
  localparam int  CW     = prism_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              cfg_tx,
  input  logic              cfg_lsb,
  input  logic              exec,
  input  logic              shift,
  input  logic              serial_in,
  output logic              serial_out,
  output logic              word_done,
  input  logic              host_wr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_rd,
  output logic [DATA_W-1:0] host_rdata,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              udf,
`ifdef PRISM_FIFO_THRESH_EN
  input  logic [CW-1:0]     thresh,
`endif
  output logic              irq
);

  localparam int BW = $clog2(DATA_W);

  tx_state_e         state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n, bit_cnt_inc;
  logic              s, last;
  logic              push, pop, push_req;
  logic [DATA_W-1:0] fifo_wdata;
  logic [DATA_W-1:0] rx_word, tx_shifted;
  logic              wd_n, ovf_set, udf_set, irq_n;

  assign s           = exec & shift;
  assign last        = (bit_cnt == BW'(DATA_W - 1));
  assign bit_cnt_inc = last ? '0 : bit_cnt + 1'b1;
  assign rx_word     = cfg_lsb ? {serial_in, shreg[DATA_W-1:1]} : {shreg[DATA_W-2:0], serial_in};
  assign tx_shifted  = cfg_lsb ? {1'b0, shreg[DATA_W-1:1]}      : {shreg[DATA_W-2:0], 1'b0};

  prism_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .head  (host_rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    wd_n       = 1'b0;
    push_req   = 1'b0;
    pop        = 1'b0;
    udf_set    = 1'b0;
    fifo_wdata = host_wdata;
    if (cfg_tx == PRISM_MODE_RX) begin
      fifo_wdata = rx_word;
      pop        = host_rd & ~empty;
      udf_set    = host_rd & empty;
      if (s) begin
        shreg_n   = rx_word;
        bit_cnt_n = bit_cnt_inc;
        wd_n      = last;
        push_req  = last;
      end
    end else begin
      push_req = host_wr;
      case (state)
        TX_IDLE: begin
          udf_set = s;
          // Load is independent of the strobe; a strobe here is an underrun.
          if (!empty) begin
            shreg_n   = host_rdata;
            pop       = 1'b1;
            bit_cnt_n = '0;
            state_n   = TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (s) begin
            shreg_n   = tx_shifted;
            bit_cnt_n = bit_cnt_inc;
            if (last) begin
              wd_n = 1'b1;
              // Reload on the same edge so words go out with no gap bit.
              if (!empty) begin
                shreg_n = host_rdata;
                pop     = 1'b1;
              end else begin
                state_n = TX_IDLE;
              end
            end
          end
        end
        default: state_n = TX_IDLE;
      endcase
    end
    // A pop on the same edge frees the slot the push needs.
    push    = push_req & (~full | pop);
    ovf_set = push_req & full & ~pop;
  end

  always_comb begin
`ifdef PRISM_FIFO_THRESH_EN
    if (cfg_tx == PRISM_MODE_TX) irq_n = (count <= thresh);
    else                         irq_n = (thresh != '0) && (count >= thresh);
`else
    irq_n = (cfg_tx == PRISM_MODE_TX) ? empty : ~empty;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state     <= TX_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      word_done <= wd_n;
      ovf       <= ovf | ovf_set;
      udf       <= udf | udf_set;
      irq       <= irq_n;
    end
  end

  assign serial_out = (state == TX_BUSY) ? (cfg_lsb ? shreg[0] : shreg[DATA_W-1]) : IDLE;

endmodule

// File: tb/tb_prism_shift_fifo.sv
// Scoreboard bench for prism_shift_fifo (DATA_W=8, DEPTH=4, IDLE=1).
module tb_prism_shift_fifo;

  logic       clk = 1'b0;
  logic       rst_n, clear, cfg_tx, cfg_lsb, exec, shift, serial_in;
  logic       host_wr, host_rd;
  logic [7:0] host_wdata, host_rdata;
  logic [2:0] count;
  logic       serial_out, word_done, full, empty, ovf, udf, irq;
`ifdef PRISM_FIFO_THRESH_EN
  logic [2:0] thresh = 3'd0;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] sb[$];
  logic       bq[$];
  logic       exp_ovf = 1'b0;
  logic       exp_udf = 1'b0;

  always #5 clk = ~clk;

  prism_shift_fifo #(.DATA_W(8), .DEPTH(4), .IDLE(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .cfg_tx     (cfg_tx),
    .cfg_lsb    (cfg_lsb),
    .exec       (exec),
    .shift      (shift),
    .serial_in  (serial_in),
    .serial_out (serial_out),
    .word_done  (word_done),
    .host_wr    (host_wr),
    .host_wdata (host_wdata),
    .host_rd    (host_rd),
    .host_rdata (host_rdata),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .ovf        (ovf),
    .udf        (udf),
`ifdef PRISM_FIFO_THRESH_EN
    .thresh     (thresh),
`endif
    .irq        (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic irq_exp(input logic tx, input int n);
`ifdef PRISM_FIFO_THRESH_EN
    if (tx) return (n <= int'(thresh));
    return (thresh != 0) && (n >= int'(thresh));
`else
    return tx ? (n == 0) : (n != 0);
`endif
  endfunction

  task automatic status(input string tag);
    tick();
    chk({tag, ".count"}, count, sb.size());
    chk({tag, ".full"},  full,  sb.size() == 4);
    chk({tag, ".empty"}, empty, sb.size() == 0);
    chk({tag, ".ovf"},   ovf,   exp_ovf);
    chk({tag, ".udf"},   udf,   exp_udf);
    chk({tag, ".irq"},   irq,   irq_exp(cfg_tx, sb.size()));
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
  endtask

  task automatic rx_word(input logic [7:0] w, input bit rd_last, input bit freeze);
    for (int i = 0; i < 8; i++) begin
      serial_in = cfg_lsb ? w[i] : w[7-i];
      exec  = 1'b1;
      shift = 1'b1;
      if (freeze && i == 3) begin
        exec = 1'b0;
        tick();
        tick();
        exec = 1'b1;
      end
      if (i == 7 && rd_last && sb.size() > 0) begin
        host_rd = 1'b1;
        chk("rd_last", host_rdata, sb.pop_front());
      end
      tick();
      if (i < 7) chk("wd_mid", word_done, 1'b0);
    end
    host_rd = 1'b0;
    shift   = 1'b0;
    chk("word_done", word_done, 1'b1);
    if (sb.size() < 4) sb.push_back(w);
    else exp_ovf = 1'b1;
    tick();
    chk("wd_low", word_done, 1'b0);
  endtask

  task automatic host_read();
    host_rd = 1'b1;
    if (sb.size() > 0) chk("rdata", host_rdata, sb.pop_front());
    else begin
      chk("rdata_empty", host_rdata, 8'h00);
      exp_udf = 1'b1;
    end
    tick();
    host_rd = 1'b0;
    chk("udf_after_rd", udf, exp_udf);
  endtask

  task automatic tx_write(input logic [7:0] w);
    host_wr    = 1'b1;
    host_wdata = w;
    for (int i = 0; i < 8; i++) bq.push_back(cfg_lsb ? w[i] : w[7-i]);
    tick();
    host_wr = 1'b0;
  endtask

  task automatic tx_drain(input bit gate);
    int nb = 0;
    tick();
    while (bq.size() > 0) begin
      exec  = 1'b1;
      shift = 1'b1;
      if (gate && nb == 3) begin
        exec = 1'b0;
        chk("tx_hold", serial_out, bq[0]);
        tick();
        chk("tx_hold2", serial_out, bq[0]);
        exec = 1'b1;
      end
      chk("tx_bit", serial_out, bq.pop_front());
      tick();
      nb++;
      chk("tx_wd", word_done, (nb % 8) == 0);
    end
    shift = 1'b0;
    chk("tx_idle", serial_out, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; cfg_tx = 1'b0; cfg_lsb = 1'b0;
    exec = 1'b0; shift = 1'b0; serial_in = 1'b0;
    host_wr = 1'b0; host_wdata = 8'h00; host_rd = 1'b0;
    tick();
    tick();
    chk("rst.count", count, 0);
    chk("rst.empty", empty, 1'b1);
    chk("rst.ovf", ovf, 1'b0);
    chk("rst.udf", udf, 1'b0);
    chk("rst.wd", word_done, 1'b0);
    chk("rst.sout", serial_out, 1'b1);
    chk("rst.irq", irq, 1'b0);
    chk("rst.rdata", host_rdata, 8'h00);
    rst_n = 1'b1;

    // RX msb-first single word
    rx_word(8'hA5, 0, 0);
    chk("rx_a5", host_rdata, 8'hA5);
    status("rx1");
    host_read();
    status("rx1_rd");

    // RX lsb-first with exec freeze mid-word
    cfg_lsb = 1'b1;
    rx_word(8'h3C, 0, 1);
    host_read();
    status("rx_lsb");

    // overflow: 5 words into depth 4
    cfg_lsb = 1'b0;
    for (int k = 1; k <= 5; k++) rx_word(8'(k * 8'h11), 0, 0);
    status("ovf");
    for (int k = 0; k < 4; k++) host_read();
    host_read();
    status("udf");

    // full with simultaneous push/pop
    pulse_clear();
    status("clr");
    for (int k = 0; k < 4; k++) rx_word(8'(8'h61 + k), 0, 0);
    rx_word(8'h65, 1, 0);
    status("full_rw");
    for (int k = 0; k < 4; k++) host_read();
    status("full_rw_drain");

`ifdef PRISM_FIFO_THRESH_EN
    pulse_clear();
    thresh = 3'd3;
    rx_word(8'h01, 0, 0);
    rx_word(8'h02, 0, 0);
    status("th2");
    rx_word(8'h03, 0, 0);
    status("th3");
    host_read();
    status("th_rd");
    host_read();
    host_read();
    thresh = 3'd0;
    status("th_done");
`endif

    // reset mid-word
    rx_word(8'h5A, 0, 0);
    exec = 1'b1; shift = 1'b1;
    for (int i = 0; i < 3; i++) begin
      serial_in = i[0];
      tick();
    end
    shift = 1'b0;
    rst_n = 1'b0;
    tick();
    sb.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    chk("mrst.count", count, 0);
    chk("mrst.rdata", host_rdata, 8'h00);
    chk("mrst.wd", word_done, 1'b0);
    chk("mrst.sout", serial_out, 1'b1);
    rst_n = 1'b1;
    rx_word(8'h96, 0, 0);
    host_read();
    status("mrst");

    // TX lsb-first back-to-back
    cfg_tx = 1'b1;
    pulse_clear();
    cfg_lsb = 1'b1;
    status("tx_start");
    tx_write(8'h3C);
    tx_write(8'hC3);
    tx_drain(0);

    // TX msb-first with exec gating
    cfg_lsb = 1'b0;
    tx_write(8'hB2);
    tx_drain(1);
    status("tx_done");

    // TX strobe while empty
    exec = 1'b1; shift = 1'b1;
    tick();
    shift = 1'b0;
    exp_udf = 1'b1;
    chk("tx_udf", udf, 1'b1);
    chk("tx_udf_sout", serial_out, 1'b1);
    pulse_clear();
    chk("tx_clr_udf", udf, 1'b0);
    chk("tx_clr_count", count, 0);
    status("tx_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
